// File: rtl/rs15_9_pkg.sv
// Shared constants, GF(2^4) helpers and FSM state type for the RS(15,9) syndrome block.
package rs15_9_pkg;

    localparam int GF_W  = 4;
    localparam int RS_N  = 15;
    localparam int RS_K  = 9;
    localparam int RS_2T = 6;

    localparam logic [GF_W:0]   PRIM_POLY = 5'b10011;
    localparam logic [GF_W-1:0] ALPHA     = 4'b0010;

    localparam logic [GF_W-1:0] ALPHA_POW [0:RS_N-1] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
        4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
    };

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } rs_state_e;

    // Multiply by x modulo the primitive polynomial.
    function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] a);
        logic [GF_W-1:0] r;
        if (a[GF_W-1]) begin
            r = {a[GF_W-2:0], 1'b0} ^ PRIM_POLY[GF_W-1:0];
        end else begin
            r = {a[GF_W-2:0], 1'b0};
        end
        return r;
    endfunction

    // Shift-and-add product; with a constant c it folds into a small XOR network.
    function automatic logic [GF_W-1:0] gf_mul_const(input logic [GF_W-1:0] a,
                                                     input logic [GF_W-1:0] c);
        logic [GF_W-1:0] acc;
        logic [GF_W-1:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < GF_W; i++) begin
            if (c[i]) begin
                acc = acc ^ sh;
            end else begin
                acc = acc;
            end
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs15_9_syn_cell.sv
// One Horner accumulator S_j <= S_j * alpha^POW ^ symbol.
module rs15_9_syn_cell
    import rs15_9_pkg::*;
#(
    parameter int POW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic            first,
    input  logic [GF_W-1:0] sym_data,
    output logic [GF_W-1:0] syn_next,
    output logic [GF_W-1:0] syn
);

    localparam logic [GF_W-1:0] MULT = ALPHA_POW[POW % RS_N];

    logic [GF_W-1:0] syn_r;
    logic [GF_W-1:0] base_s;

    // Next accumulator value; the first symbol of a frame starts from zero.
    always_comb begin
        base_s = 4'h0;
        if (first) begin
            base_s = 4'h0;
        end else begin
            base_s = gf_mul_const(syn_r, MULT);
        end
        syn_next = base_s ^ sym_data;
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syn_r <= 4'h0;
        end else if (clr) begin
            syn_r <= 4'h0;
        end else if (load) begin
            syn_r <= syn_next;
        end else begin
            syn_r <= syn_r;
        end
    end

    assign syn = syn_r;

endmodule

// File: rtl/rs15_9_syndrome.sv
// RS(15,9) syndrome calculator: accumulates a 15-symbol frame, then holds S1..S6 until consumed.
module rs15_9_syndrome
    import rs15_9_pkg::*;
#(
    parameter int SYN_NUM = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    input  logic [GF_W-1:0]         sym_data,
    input  logic                    sym_last,
    output logic                    syn_valid,
    input  logic                    syn_ready,
    output logic [GF_W*RS_2T-1:0]   syndrome,
    output logic                    err_detect,
    output logic                    frame_err
);

    rs_state_e               state_r;
    logic [3:0]              cnt_r;
    logic                    err_detect_r;
    logic                    frame_err_r;
    logic                    sym_xfer_s;
    logic                    syn_xfer_s;
    logic                    cnt_end_s;
    logic                    frame_end_s;
    logic [GF_W*RS_2T-1:0]   syn_next_s;
    logic [GF_W*RS_2T-1:0]   syn_s;

    assign sym_xfer_s  = sym_valid && (state_r == ST_ACCUM);
    assign syn_xfer_s  = syn_ready && (state_r == ST_HOLD);
    assign cnt_end_s   = (cnt_r == 4'd14);
    assign frame_end_s = sym_xfer_s && (sym_last || cnt_end_s);

    genvar gi;
    generate
        for (gi = 0; gi < SYN_NUM; gi++) begin : g_cell
            rs15_9_syn_cell #(.POW(gi + 1)) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (syn_xfer_s),
                .load     (sym_xfer_s),
                .first    (cnt_r == 4'd0),
                .sym_data (sym_data),
                .syn_next (syn_next_s[gi*GF_W +: GF_W]),
                .syn      (syn_s[gi*GF_W +: GF_W])
            );
        end
    endgenerate

    // Frame FSM, symbol counter and the status flags that travel with the syndromes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_ACCUM;
            cnt_r        <= 4'd0;
            err_detect_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (frame_end_s) begin
                        state_r      <= ST_HOLD;
                        cnt_r        <= 4'd0;
                        err_detect_r <= |syn_next_s;
                        frame_err_r  <= (sym_last && !cnt_end_s) || (!sym_last && cnt_end_s);
                    end else if (sym_xfer_s) begin
                        cnt_r <= cnt_r + 4'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_HOLD: begin
                    if (syn_xfer_s) begin
                        state_r      <= ST_ACCUM;
                        err_detect_r <= 1'b0;
                        frame_err_r  <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r      <= ST_ACCUM;
                    cnt_r        <= 4'd0;
                    err_detect_r <= 1'b0;
                    frame_err_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sym_ready  = (state_r == ST_ACCUM);
    assign syn_valid  = (state_r == ST_HOLD);
    assign syndrome   = syn_s;
    assign err_detect = err_detect_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_rs15_9_syndrome.sv
// Scoreboard bench for rs15_9_syndrome: frames are modelled by direct polynomial evaluation.
module tb_rs15_9_syndrome;

    typedef struct packed {
        logic [23:0] syn;
        logic        err;
        logic        ferr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sym_valid;
    logic        sym_ready;
    logic [3:0]  sym_data;
    logic        sym_last;
    logic        syn_valid;
    logic        syn_ready;
    logic [23:0] syndrome;
    logic        err_detect;
    logic        frame_err;

    int   total;
    int   bad;
    exp_t exp_q[$];
    logic [3:0] fb [15];
    logic [3:0] apow [15];

    rs15_9_syndrome #(.SYN_NUM(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_data   (sym_data),
        .sym_last   (sym_last),
        .syn_valid  (syn_valid),
        .syn_ready  (syn_ready),
        .syndrome   (syndrome),
        .err_detect (err_detect),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial-basis product with reduction by x^4+x+1.
    function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (8'({4'h0, a}) << i);
        for (int i = 7; i >= 4; i--)
            if (p[i]) p = p ^ (8'h13 << (i - 4));
        return p[3:0];
    endfunction

    // S_j = sum_k fb[k] * alpha^(j*(len-1-k)).
    function automatic exp_t model(input int len, input bit use_last);
        exp_t e;
        logic [3:0] s;
        e.syn = 24'h0;
        for (int j = 1; j <= 6; j++) begin
            s = 4'h0;
            for (int k = 0; k < len; k++)
                s = s ^ m_mul(fb[k], apow[(j * (len - 1 - k)) % 15]);
            e.syn[(j-1)*4 +: 4] = s;
        end
        e.err  = (e.syn != 24'h0);
        e.ferr = (use_last && len < 15) || (!use_last && len == 15);
        return e;
    endfunction

    task automatic drive_frame(input int len, input bit use_last, input bit has_exp, input exp_t exp_v);
        int w;
        w = 0;
        while (sym_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 20) begin
            bad++;
            $display("FAIL ready_wait: sym_ready=%b required 1 within 20 cycles", sym_ready);
        end
        if (has_exp) exp_q.push_back(exp_v);
        else         exp_q.push_back(model(len, use_last));
        for (int k = 0; k < len; k++) begin
            sym_valid = 1'b1;
            sym_data  = fb[k];
            sym_last  = use_last && (k == len - 1);
            @(posedge clk); #1;
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        sym_data  = 4'h0;
        total++;
        if (syn_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency: syn_valid=%b required 1 one cycle after last symbol", syn_valid);
        end
    endtask

    task automatic pop_check(input string name, input int hold);
        exp_t e;
        logic [23:0] cap;
        int w;
        w = 0;
        while (syn_valid !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        total++;
        if (w >= 20 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_wait: syn_valid=%b queue=%0d required result", name, syn_valid, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        if (syndrome !== e.syn) begin
            bad++;
            $display("FAIL %s_syn: got %h required %h", name, syndrome, e.syn);
        end
        total++;
        if (err_detect !== e.err) begin
            bad++;
            $display("FAIL %s_err: got %b required %b", name, err_detect, e.err);
        end
        total++;
        if (frame_err !== e.ferr) begin
            bad++;
            $display("FAIL %s_ferr: got %b required %b", name, frame_err, e.ferr);
        end
        cap = syndrome;
        for (int h = 0; h < hold; h++) begin
            sym_valid = 1'b1;
            sym_data  = 4'hF;
            @(posedge clk); #1;
            total++;
            if (syn_valid !== 1'b1 || sym_ready !== 1'b0 || syndrome !== e.syn) begin
                bad++;
                $display("FAIL %s_hold: valid=%b ready=%b syn=%h required 1 0 %h (cap %h)",
                         name, syn_valid, sym_ready, syndrome, e.syn, cap);
            end
        end
        sym_valid = 1'b0;
        sym_data  = 4'h0;
        syn_ready = 1'b1;
        @(posedge clk); #1;
        syn_ready = 1'b0;
        total++;
        if (sym_ready !== 1'b1 || syn_valid !== 1'b0 || syndrome !== 24'h0) begin
            bad++;
            $display("FAIL %s_release: ready=%b valid=%b syn=%h required 1 0 000000",
                     name, sym_ready, syn_valid, syndrome);
        end
    endtask

    task automatic fill_zero();
        for (int k = 0; k < 15; k++) fb[k] = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sym_ready !== 1'b1 || syn_valid !== 1'b0 || syndrome !== 24'h0 ||
            err_detect !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset: ready=%b valid=%b syn=%h err=%b ferr=%b required 1 0 000000 0 0",
                     sym_ready, syn_valid, syndrome, err_detect, frame_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_known_frames();
        fill_zero();
        drive_frame(15, 1'b1, 1'b1, exp_t'({24'h000000, 1'b0, 1'b0}));
        pop_check("zero", 0);
        fill_zero();
        fb[14] = 4'h5;
        drive_frame(15, 1'b1, 1'b1, exp_t'({24'h555555, 1'b1, 1'b0}));
        pop_check("last5", 0);
        fill_zero();
        fb[0] = 4'h1;
        drive_frame(15, 1'b1, 1'b1, exp_t'({24'hA7EFD9, 1'b1, 1'b0}));
        pop_check("first1", 0);
    endtask

    task automatic test_hold();
        for (int k = 0; k < 15; k++) fb[k] = 4'(k + 3);
        drive_frame(15, 1'b1, 1'b0, exp_t'(26'h0));
        pop_check("hold", 3);
    endtask

    task automatic test_frame_err();
        for (int k = 0; k < 15; k++) fb[k] = 4'(15 - k);
        drive_frame(10, 1'b1, 1'b0, exp_t'(26'h0));
        pop_check("short", 0);
        drive_frame(15, 1'b1, 1'b0, exp_t'(26'h0));
        pop_check("after_short", 0);
        drive_frame(15, 1'b0, 1'b0, exp_t'(26'h0));
        pop_check("no_last", 0);
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 7; k++) begin
            sym_valid = 1'b1;
            sym_data  = 4'(k + 9);
            @(posedge clk); #1;
        end
        sym_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if (syn_valid !== 1'b0 || sym_ready !== 1'b1 || syndrome !== 24'h0) begin
            bad++;
            $display("FAIL midreset: valid=%b ready=%b syn=%h required 0 1 000000",
                     syn_valid, sym_ready, syndrome);
        end
        fill_zero();
        drive_frame(15, 1'b1, 1'b1, exp_t'({24'h000000, 1'b0, 1'b0}));
        pop_check("post_reset", 0);
    endtask

    task automatic test_back_to_back();
        int len;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 15; k++) fb[k] = 4'($urandom_range(0, 15));
            len = (f % 2 == 0) ? 15 : int'($urandom_range(1, 14));
            drive_frame(len, 1'b1, 1'b0, exp_t'(26'h0));
            pop_check("b2b", 0);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        sym_valid = 1'b0;
        sym_data  = 4'h0;
        sym_last  = 1'b0;
        syn_ready = 1'b0;
        apow[0]   = 4'h1;
        for (int i = 1; i < 15; i++) apow[i] = m_mul(apow[i-1], 4'h2);
        @(posedge clk); #1;
        test_reset();
        test_known_frames();
        test_hold();
        test_frame_err();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs15_9_syndrome.md
RS15_9_SYNDROME -- requirements
Module: rs15_9_syndrome

Interface
REQ-001 SHALL have parameter SYN_NUM, default 6, number of syndromes computed (2t for RS(15,9), t=3); only 6 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port sym_valid  input  1  input symbol present.
REQ-005 SHALL have port sym_ready  output  1  block accepts a symbol this cycle.
REQ-006 SHALL have port sym_data  input  4  received symbol; first symbol of a frame is coefficient of x^14, last is x^0.
REQ-007 SHALL have port sym_last  input  1  marks final symbol of a frame.
REQ-008 SHALL have port syn_valid  output  1  syndrome result present.
REQ-009 SHALL have port syn_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port syndrome  output  24  S1 in [3:0] through S6 in [23:20].
REQ-011 SHALL have port err_detect  output  1  any syndrome nonzero.
REQ-012 SHALL have port frame_err  output  1  frame length was not 15 symbols.

Function
REQ-013 Arithmetic SHALL be GF(2^4) with primitive polynomial x^4+x+1 and alpha = 4'b0010.
REQ-014 Symbol transfer SHALL occur on a cycle where sym_valid and sym_ready are both 1.
REQ-015 Result transfer SHALL occur on a cycle where syn_valid and syn_ready are both 1.
REQ-016 FSM SHALL have two states: ACCUM (sym_ready=1, syn_valid=0) and HOLD (sym_ready=0, syn_valid=1).
REQ-017 In ACCUM, each symbol transfer SHALL update S_j <= S_j*alpha^j XOR sym_data for j=1..6 (Horner), with S_j treated as 0 for the first symbol.
REQ-018 A 4-bit symbol counter SHALL count 0..14, clearing at frame end.
REQ-019 Frame end SHALL be a symbol transfer with sym_last=1 or with counter=14, whichever comes first.
REQ-020 On frame end, FSM SHALL enter HOLD on the next edge, with syndrome, err_detect and frame_err valid on that same cycle (latency 1 cycle after the final symbol).
REQ-021 frame_err SHALL be 1 if sym_last=1 at counter<14, or sym_last=0 at counter=14; otherwise 0.
REQ-022 Syndromes from a short frame SHALL still be output, flagged by frame_err.
REQ-023 In HOLD, syndrome, err_detect and frame_err SHALL stay stable until the result transfer.
REQ-024 On the result transfer, FSM SHALL return to ACCUM on the next edge, and syndrome registers SHALL clear for the next frame.
REQ-025 sym_ready SHALL be a pure register decode of the state, with no combinational path from syn_ready.
REQ-026 sym_valid SHALL be ignored in HOLD, with no symbol loss since sym_ready=0.
REQ-027 err_detect SHALL be the OR of all 24 syndrome bits, registered together with the syndromes.

Reset
REQ-028 On rst_n=0 at a clock edge, the block SHALL enter ACCUM with counter=0, syndrome=0, err_detect=0, frame_err=0, syn_valid=0 and sym_ready=1.
REQ-029 Reset mid-frame or in HOLD SHALL discard all partial or pending results, with no output transfer.

Structure
REQ-030 Package rs15_9_pkg SHALL hold: GF width 4, N=15, K=9, 2t=6, the primitive polynomial constant, the alpha^0..alpha^14 table, a GF constant-multiply function, and the FSM state enum.
REQ-031 Sub-module rs15_9_syn_cell SHALL be one Horner accumulator per syndrome, parameterized by power j, with 6 instances.

Verification
REQ-032 Bench SHALL cover: 15 zero symbols -> syndrome=24'h000000, err_detect=0, frame_err=0, syn_valid 1 cycle after the last symbol.
REQ-033 Bench SHALL cover: 14 zeros then a last symbol of 4'h5 -> syndrome=24'h555555, err_detect=1.
REQ-034 Bench SHALL cover: first symbol 4'h1, then 14 zeros -> syndrome=24'hA7EFD9 (S1..S6 = alpha^14, alpha^13, alpha^12, alpha^11, alpha^10, alpha^9), err_detect=1.
REQ-035 Bench SHALL cover: syn_ready held 0 for 3 cycles in HOLD -> syn_valid=1, sym_ready=0 and syndrome unchanged throughout; sym_ready=1 the cycle after the transfer.
REQ-036 Bench SHALL cover: sym_last on the 10th symbol -> frame_err=1 and HOLD entered; next 15-symbol frame -> frame_err=0.
REQ-037 Bench SHALL cover: rst_n=0 for 1 cycle after 7 symbols, then a 15-zero frame -> syndrome=0, frame_err=0.
